// File: rtl/pll_reset_sequencer.sv
// Power-up / relock sequencer for the system PLL, clocked by the free-running refclk.
// Pulses the PLL reset, waits for lock with a bounded retry count, qualifies lock, then runs.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    // Terminal counts: a phase lasting N cycles ends on the edge where the counter reads N-1.
    localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [2:0]       RetryMax   = 3'(MAX_RETRIES);

    logic             r_sync1;
    logic             r_lock_s;
    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]       r_retry;
    logic [2:0]       w_retry_d;
    logic [2:0]       w_retry_inc;
    logic [7:0]       r_loss;
    logic [7:0]       w_loss_d;
    logic             r_pll_rst;
    logic             r_sys_ready;
    logic             r_fault;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_retry_d   = r_retry;
        w_loss_d    = r_loss;
        w_retry_inc = r_retry + 3'd1;
        unique case (r_state)
            StResetPll: begin
                if (r_cnt == RstLast) begin
                    w_state_d = StWaitLock;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StWaitLock: begin
                // Lock seen on the timeout cycle takes priority over the retry.
                if (r_lock_s) begin
                    w_state_d = StStable;
                    w_cnt_d   = '0;
                end else if (r_cnt == TimeoutLast) begin
                    w_cnt_d   = '0;
                    w_retry_d = w_retry_inc;
                    w_state_d = (w_retry_inc == RetryMax) ? StFault : StResetPll;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StStable: begin
                if (!r_lock_s) begin
                    w_state_d = StWaitLock;
                    w_cnt_d   = '0;
                end else if (r_cnt == StableLast) begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                    w_retry_d = '0;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StRun: begin
                w_cnt_d = '0;
                if (!r_lock_s) begin
                    w_state_d = StResetPll;
                    if (r_loss != 8'hFF) begin
                        w_loss_d = r_loss + 8'd1;
                    end
                end else if (relock_req) begin
                    w_state_d = StResetPll;
                end
            end
            StFault: begin
                w_cnt_d = '0;
                if (relock_req) begin
                    w_state_d = StResetPll;
                    w_retry_d = '0;
                end
            end
            default: begin
                w_state_d = StResetPll;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StResetPll;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_retry     <= w_retry_d;
            r_loss      <= w_loss_d;
            r_pll_rst   <= (w_state_d == StResetPll) || (w_state_d == StFault);
            r_sys_ready <= (w_state_d == StRun);
            r_fault     <= (w_state_d == StFault);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_ready = r_sys_ready;
    assign fault     = r_fault;
    assign state_o   = r_state;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule
